// File: rtl/bnn_layer_gen.sv
// -----------------------------------------------------------------------------
// bnn_layer_gen -- binary convolution layer back-end
//
// Purpose:
//   Accepts one XNOR window beat (CH channels x KW taps) per valid cycle and
//   forms the signed +/-1 sum 2*popcount - CH*KW. That sum is thresholded
//   against a per-filter threshold whose compare sense is set by a polarity bit.
//   The resulting bit is either shifted straight into a frame buffer, or first
//   reduced with a 2x2 stride-2 max (OR) / min (AND) pool over an LB-wide row.
//
// Pipeline:
//   stage 1 : registered sum, threshold and polarity (v1)
//   stage 2 : compare + position counters + pooling + frame-buffer shift, all
//             updated on the same edge; the shifted bit is visible 2 cycles
//             after its input beat.
//
// Handshake: valid-only streaming. A beat is consumed on every rising edge
//   where iVALID=1 and iSTART=0; there is no ready/back-pressure and no stall,
//   so back-to-back beats are accepted every cycle. oVALID_BIT marks each cycle
//   in which a new bit entered oDATA; oDONE marks the last bit of a frame.
//
// Ports:
//   iCLK, iRST    clock, asynchronous active-high reset
//   iSTART        synchronous clear of pipeline, counters, line and frame buffer
//   iVALID        window beat valid
//   iDATA         activations, channel c at [(c+1)*KW-1 : c*KW]
//   iWEIGHT       weights, same packing as iDATA
//   iTH           signed threshold for the beat's filter
//   iPOL          1: bit = sum <= iTH, AND (min) pooling
//                 0: bit = sum >  iTH, OR  (max) pooling
//   iPOOL         1: 2x2 stride-2 pooling, 0: no pooling (stable per frame)
//   oDATA         frame buffer, newest bit at LSB
//   oVALID_BIT    a bit was shifted into oDATA this cycle
//   oDONE         one-cycle pulse with the last bit of a frame
//
// Optional build macro BNN_SUM_TAP_EN:
//   adds oSUM (stage-1 registered sum) and oSUM_VALID (v1) for debug and
//   threshold calibration. Without the macro neither port nor logic exists.
// -----------------------------------------------------------------------------
module bnn_layer_gen #(
  parameter int CH   = 48,
  parameter int KW   = 9,
  parameter int TH   = 11,
  parameter int LB   = 12,
  parameter int ROWS = 10,
  parameter int BL   = 120
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic                 iVALID,
  input  logic [CH*KW-1:0]     iDATA,
  input  logic [CH*KW-1:0]     iWEIGHT,
  input  logic signed [TH-1:0] iTH,
  input  logic                 iPOL,
  input  logic                 iPOOL,
  output logic [BL-1:0]        oDATA,
  output logic                 oVALID_BIT,
  output logic                 oDONE
`ifdef BNN_SUM_TAP_EN
  ,
  output logic signed [TH-1:0] oSUM,
  output logic                 oSUM_VALID
`endif
);

  localparam int NBITS  = CH * KW;
  localparam int COL_W  = (LB > 1) ? $clog2(LB) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int HALF_W = (LB / 2 > 1) ? $clog2(LB / 2) : 1;

  // ---------------------------------------------------------------------------
  // Stage-1 combinational sum. The popcount never exceeds CH*KW, which is
  // below 2^(TH-1), so doubling it still fits in TH bits and the subtraction
  // yields the correct two's-complement result.
  // ---------------------------------------------------------------------------
  logic [NBITS-1:0]     xnorBits;
  logic [TH-1:0]        popCount;
  logic signed [TH-1:0] sumNext;

  always_comb begin
    xnorBits = ~(iDATA ^ iWEIGHT);
    popCount = '0;
    for (int i = 0; i < NBITS; i++) begin
      popCount = popCount + TH'(xnorBits[i]);
    end
    sumNext = $signed((popCount << 1) - TH'(NBITS));
  end

  // Stage-1 registers
  logic                 v1;
  logic signed [TH-1:0] sum1;
  logic signed [TH-1:0] th1;
  logic                 pol1;

  // Position counters and pooling storage
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic                 heldBit;
  logic [LB/2-1:0]      lineBuf;

  // ---------------------------------------------------------------------------
  // Stage-2 combinational decisions, evaluated from the stage-1 registers and
  // committed on the same edge that shifts the frame buffer.
  // ---------------------------------------------------------------------------
  logic              bit2;
  logic              pairBit;
  logic              pooledBit;
  logic              newBit;
  logic              shiftEn;
  logic              lastCol;
  logic              lastRow;
  logic [HALF_W-1:0] colHalf;

  always_comb begin
    bit2      = pol1 ? (sum1 <= th1) : (sum1 > th1);
    colHalf   = HALF_W'(col >> 1);
    // Horizontal pair reduction (only meaningful on odd columns)
    pairBit   = pol1 ? (heldBit & bit2) : (heldBit | bit2);
    // Vertical reduction against the pair stored on the even row above
    pooledBit = pol1 ? (pairBit & lineBuf[colHalf]) : (pairBit | lineBuf[colHalf]);
    lastCol   = (col == COL_W'(LB - 1));
    lastRow   = (row == ROW_W'(ROWS - 1));
    // With pooling, only the bottom-right pixel of each 2x2 block emits a bit
    shiftEn   = v1 && (!iPOOL || (col[0] && row[0]));
    newBit    = iPOOL ? pooledBit : bit2;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1         <= 1'b0;
      sum1       <= '0;
      th1        <= '0;
      pol1       <= 1'b0;
      col        <= '0;
      row        <= '0;
      heldBit    <= 1'b0;
      lineBuf    <= '0;
      oDATA      <= '0;
      oVALID_BIT <= 1'b0;
      oDONE      <= 1'b0;
    end else if (iSTART) begin
      // Discards any frame in progress, including a beat presented this cycle
      v1         <= 1'b0;
      sum1       <= '0;
      th1        <= '0;
      pol1       <= 1'b0;
      col        <= '0;
      row        <= '0;
      heldBit    <= 1'b0;
      lineBuf    <= '0;
      oDATA      <= '0;
      oVALID_BIT <= 1'b0;
      oDONE      <= 1'b0;
    end else begin
      // Stage 1
      v1 <= iVALID;
      if (iVALID) begin
        sum1 <= sumNext;
        th1  <= iTH;
        pol1 <= iPOL;
      end

      // Stage 2: frame buffer and flags
      oVALID_BIT <= shiftEn;
      // The last frame position is an odd row / odd column, so in pooled mode
      // it always coincides with an emitted pooled bit.
      oDONE      <= v1 && lastCol && lastRow;
      if (shiftEn) begin
        oDATA <= {oDATA[BL-2:0], newBit};
      end

      // Stage 2: position counters and pooling state
      if (v1) begin
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end

        if (iPOOL) begin
          if (!col[0]) begin
            heldBit <= bit2;
          end else if (!row[0]) begin
            lineBuf[colHalf] <= pairBit;
          end
        end
      end
    end
  end

`ifdef BNN_SUM_TAP_EN
  // Debug taps come straight from stage 1, so they share its reset and clear
  assign oSUM       = sum1;
  assign oSUM_VALID = v1;
`endif

endmodule

// File: tb/tb_bnn_layer_gen.sv
// -----------------------------------------------------------------------------
// tb_bnn_layer_gen -- self-checking bench for bnn_layer_gen
//
// A reference model computes each beat's bit from the popcount rule, places it
// in a full-frame picture, and (when pooling) reduces completed 2x2 blocks
// directly from that picture. Every emitted bit produces an expected frame
// buffer value, done flag and arrival cycle in a scoreboard queue that a
// negedge monitor consumes. Directed steps add checks for reset, threshold
// boundaries, the single-pixel pooled frames, iSTART and async reset.
// -----------------------------------------------------------------------------
module tb_bnn_layer_gen;

  localparam int CH   = 48;
  localparam int KW   = 9;
  localparam int TH   = 11;
  localparam int LB   = 12;
  localparam int ROWS = 10;
  localparam int BL   = 120;
  localparam int N    = CH * KW;
  localparam int FRAME = LB * ROWS;
  localparam int PFRAME = (LB / 2) * (ROWS / 2);
  localparam logic [N-1:0] ALL1 = '1;
  localparam logic [N-1:0] ALL0 = '0;

  // ---------------- clock / reset / DUT ----------------
  logic                 iCLK;
  logic                 iRST;
  logic                 iSTART;
  logic                 iVALID;
  logic [N-1:0]         iDATA;
  logic [N-1:0]         iWEIGHT;
  logic signed [TH-1:0] iTH;
  logic                 iPOL;
  logic                 iPOOL;
  logic [BL-1:0]        oDATA;
  logic                 oVALID_BIT;
  logic                 oDONE;
`ifdef BNN_SUM_TAP_EN
  logic signed [TH-1:0] oSUM;
  logic                 oSUM_VALID;
`endif

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  bnn_layer_gen #(
    .CH(CH), .KW(KW), .TH(TH), .LB(LB), .ROWS(ROWS), .BL(BL)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iSTART    (iSTART),
    .iVALID    (iVALID),
    .iDATA     (iDATA),
    .iWEIGHT   (iWEIGHT),
    .iTH       (iTH),
    .iPOL      (iPOL),
    .iPOOL     (iPOOL),
    .oDATA     (oDATA),
    .oVALID_BIT(oVALID_BIT),
    .oDONE     (oDONE)
`ifdef BNN_SUM_TAP_EN
    ,
    .oSUM      (oSUM),
    .oSUM_VALID(oSUM_VALID)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [BL-1:0] data;
    logic          done;
    logic [31:0]   cyc;
  } expT;

  typedef struct packed {
    logic signed [TH-1:0] sum;
    logic [31:0]          cyc;
  } sumT;

  expT expQ[$];
  sumT sumQ[$];
  int  doneCyc[$];
  int  compared = 0;
  int  mismatched = 0;

  task automatic chk(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int            mPos;
  logic          mFrame[ROWS][LB];
  logic [BL-1:0] mBuf;

  task automatic model_reset();
    mPos = 0;
    mBuf = '0;
    expQ.delete();
    sumQ.delete();
  endtask

  task automatic model_beat(input logic [N-1:0] d, input logic [N-1:0] w,
                            input logic signed [TH-1:0] th, input logic pol);
    int   pc, s, r, c;
    logic b, outBit, emit;
    expT  e;
    sumT  se;
    pc = $countones(~(d ^ w));
    s  = 2 * pc - N;
    b  = pol ? (s <= int'(th)) : (s > int'(th));
    se.sum = TH'(s);
    se.cyc = 32'(cyc + 1);
    sumQ.push_back(se);
    r = mPos / LB;
    c = mPos % LB;
    mFrame[r][c] = b;
    emit   = 1'b0;
    outBit = b;
    if (!iPOOL) begin
      emit = 1'b1;
    end else if ((r % 2 == 1) && (c % 2 == 1)) begin
      emit = 1'b1;
      if (pol) outBit = mFrame[r-1][c-1] & mFrame[r-1][c] & mFrame[r][c-1] & b;
      else     outBit = mFrame[r-1][c-1] | mFrame[r-1][c] | mFrame[r][c-1] | b;
    end
    if (emit) begin
      mBuf   = {mBuf[BL-2:0], outBit};
      e.data = mBuf;
      e.done = (mPos == FRAME - 1);
      e.cyc  = 32'(cyc + 2);
      expQ.push_back(e);
    end
    mPos = (mPos + 1) % FRAME;
  endtask

  // ---------------- monitor ----------------
  always @(negedge iCLK) begin
    expT  e;
    logic expNow;
    expNow = (expQ.size() > 0) && (int'(expQ[0].cyc) <= cyc);
    chk("valid_bit", BL'(oVALID_BIT), BL'(expNow));
    if (oVALID_BIT && expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("frame_data", oDATA, e.data);
      chk("done_flag", BL'(oDONE), BL'(e.done));
      chk("bit_cycle", BL'(cyc), BL'(e.cyc));
    end else begin
      if (expNow) void'(expQ.pop_front());
      chk("done_idle", BL'(oDONE), BL'(1'b0));
    end
    if (oDONE) doneCyc.push_back(cyc);
`ifdef BNN_SUM_TAP_EN
    if (oSUM_VALID) begin
      if (sumQ.size() > 0) begin
        sumT se;
        se = sumQ.pop_front();
        chk("sum_tap", BL'(oSUM), BL'(se.sum));
        chk("sum_cycle", BL'(cyc), BL'(se.cyc));
      end else begin
        chk("sum_valid", BL'(oSUM_VALID), BL'(1'b0));
      end
    end
`endif
  end

  // ---------------- driver tasks ----------------
  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic send_beat(input logic [N-1:0] d, input logic [N-1:0] w,
                           input logic signed [TH-1:0] th, input logic pol);
    @(negedge iCLK);
    #1;
    iVALID  = 1'b1;
    iDATA   = d;
    iWEIGHT = w;
    iTH     = th;
    iPOL    = pol;
    model_beat(d, w, th, pol);
  endtask

  task automatic send_rand(input logic pol);
    int t;
    t = int'($urandom_range(0, 80)) - 40;
    send_beat(rand_vec(), rand_vec(), TH'(t), pol);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      #1;
      iVALID = 1'b0;
    end
  endtask

  // iSTART with a live beat on the same cycle; the beat must be ignored
  task automatic do_start();
    @(negedge iCLK);
    #1;
    iSTART  = 1'b1;
    iVALID  = 1'b1;
    iDATA   = ALL1;
    iWEIGHT = ALL1;
    iTH     = '0;
    iPOL    = 1'b0;
    model_reset();
    @(negedge iCLK);
    #1;
    iSTART = 1'b0;
    iVALID = 1'b0;
    chk("start_data", oDATA, '0);
    chk("start_valid", BL'(oVALID_BIT), '0);
  endtask

  // ---------------- directed sequence ----------------
  logic [BL-1:0] altExp;
  logic [BL-1:0] poolExp;
  int            n0;
  int            pooledIdx;

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iVALID = 1'b0; iDATA = '0; iWEIGHT = '0;
    iTH = '0; iPOL = 1'b0; iPOOL = 1'b0;
    model_reset();
    repeat (3) @(negedge iCLK);
    chk("reset_data", oDATA, '0);
    chk("reset_valid", BL'(oVALID_BIT), '0);
    chk("reset_done", BL'(oDONE), '0);
`ifdef BNN_SUM_TAP_EN
    chk("reset_sum", BL'(oSUM), '0);
    chk("reset_sum_valid", BL'(oSUM_VALID), '0);
`endif
    #1 iRST = 1'b0;

    // All match: sum = +432 > 0 -> bit 1 two cycles later
    send_beat(ALL1, ALL1, '0, 1'b0);
    idle(1);
`ifdef BNN_SUM_TAP_EN
    chk("sum_432", BL'(oSUM), BL'(TH'(N)));
`endif
    @(negedge iCLK);
    chk("match_bit0", BL'(oDATA[0]), BL'(1'b1));

    // All mismatch (sum -432) and the sum==threshold boundary at 0
    send_beat(ALL0, ALL1, TH'(-N), 1'b0);
    send_beat(ALL0, ALL1, TH'(-N), 1'b1);
    send_beat({{(N/2){1'b0}}, {(N/2){1'b1}}}, ALL1, '0, 1'b0);
    send_beat({{(N/2){1'b0}}, {(N/2){1'b1}}}, ALL1, '0, 1'b1);
    idle(2);
    chk("thresh_bits", BL'(oDATA[3:0]), BL'(4'b0101));

    // No-pool frame, alternating above/below threshold
    iPOOL = 1'b0;
    do_start();
    n0 = doneCyc.size();
    for (int j = 0; j < FRAME; j++) begin
      if (j % 2 == 0) send_beat(ALL1, ALL1, '0, 1'b0);
      else            send_beat(ALL0, ALL1, '0, 1'b0);
    end
    idle(2);
    for (int k = 0; k < BL; k++) altExp[k] = (k % 2 == 1);
    chk("alt_frame", oDATA, altExp);
    chk("alt_done_count", BL'(doneCyc.size() - n0), BL'(1));

    // Pooled, max: single 1 at row 2 col 5 -> pooled block (1,2) only
    pooledIdx = 1 * (LB / 2) + 2;
    iPOOL = 1'b1;
    do_start();
    n0 = doneCyc.size();
    for (int j = 0; j < FRAME; j++) begin
      if (j == 2 * LB + 5) send_beat(ALL1, ALL1, '0, 1'b0);
      else                 send_beat(ALL0, ALL1, '0, 1'b0);
    end
    idle(2);
    poolExp = '0;
    poolExp[PFRAME - 1 - pooledIdx] = 1'b1;
    chk("pool_max_frame", oDATA, poolExp);
    chk("pool_max_done", BL'(doneCyc.size() - n0), BL'(1));

    // Pooled, min: single 0 at row 2 col 5 with inverted polarity
    do_start();
    n0 = doneCyc.size();
    for (int j = 0; j < FRAME; j++) begin
      if (j == 2 * LB + 5) send_beat(ALL1, ALL1, '0, 1'b1);
      else                 send_beat(ALL0, ALL1, '0, 1'b1);
    end
    idle(2);
    poolExp = '0;
    for (int k = 0; k < PFRAME; k++) poolExp[k] = 1'b1;
    poolExp[PFRAME - 1 - pooledIdx] = 1'b0;
    chk("pool_min_frame", oDATA, poolExp);
    chk("pool_min_done", BL'(doneCyc.size() - n0), BL'(1));

    // Random pooled frame with one polarity for the whole frame
    begin
      logic p;
      p = 1'($urandom_range(0, 1));
      do_start();
      n0 = doneCyc.size();
      for (int j = 0; j < FRAME; j++) send_rand(p);
      idle(2);
      chk("pool_rand_done", BL'(doneCyc.size() - n0), BL'(1));
    end

    // iSTART mid-frame after 50 beats, then a full new frame
    iPOOL = 1'b0;
    do_start();
    for (int j = 0; j < 50; j++) send_rand(1'($urandom_range(0, 1)));
    do_start();
    n0 = doneCyc.size();
    for (int j = 0; j < FRAME; j++) send_rand(1'($urandom_range(0, 1)));
    // Two further frames streamed with no gap
    for (int j = 0; j < 2 * FRAME; j++) send_rand(1'($urandom_range(0, 1)));
    idle(2);
    chk("stream_done_count", BL'(doneCyc.size() - n0), BL'(3));
    chk("stream_done_gap", BL'(doneCyc[n0 + 2] - doneCyc[n0 + 1]), BL'(FRAME));

    // Async reset mid-stream: outputs clear before the next clock edge
    for (int j = 0; j < 20; j++) send_rand(1'($urandom_range(0, 1)));
    #2 iRST = 1'b1;
    #1;
    chk("arst_data", oDATA, '0);
    chk("arst_valid", BL'(oVALID_BIT), '0);
    chk("arst_done", BL'(oDONE), '0);
    model_reset();
    iVALID = 1'b0;
    @(negedge iCLK);
    #1 iRST = 1'b0;
    n0 = doneCyc.size();
    for (int j = 0; j < FRAME; j++) send_rand(1'($urandom_range(0, 1)));
    idle(3);
    chk("arst_frame_done", BL'(doneCyc.size() - n0), BL'(1));
    chk("queue_drained", BL'(expQ.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
